// File: rtl/sipo_receiver_if.sv
// Handshake/bus bundle for sipo_receiver: serial input side plus the
// registered parallel output side.
interface sipo_receiver_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             en;
    logic             sin;
    logic             ack;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;
    logic             overrun;

    // Producer/consumer side driving the receiver.
    modport master (
        output start, en, sin, ack,
        input  data, valid, busy, overrun
    );

    // The receiver itself.
    modport slave (
        input  start, en, sin, ack,
        output data, valid, busy, overrun
    );
endinterface

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out frame receiver. MSB-first bits are shifted in on
// en strobes after a start strobe; a completed frame is presented on data
// with a valid/ack handshake and a sticky overrun flag for dropped frames.
module sipo_receiver #(
    parameter int WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst,
    sipo_receiver_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_word;
    logic             w_done;

    assign w_word = {r_shr[WIDTH-2:0], bus.sin};
    // start has priority over en, so a restart never completes a frame.
    assign w_done = (r_state == SHIFT) && !bus.start && bus.en && (r_cnt == LAST_CNT);

    // Frame FSM, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= SHIFT;
                        r_shr   <= '0;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.start) begin
                        r_shr <= '0;
                        r_cnt <= '0;
                    end else if (bus.en) begin
                        r_shr <= w_word;
                        if (w_done) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output word, valid/ack handshake and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || bus.ack) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && bus.ack) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.busy    = (r_state == SHIFT);
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_sipo_receiver.sv
// Directed self-checking bench for sipo_receiver with a completion scoreboard.
module tb_sipo_receiver;
    localparam int W = 6;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_over;

    sipo_receiver_if #(.WIDTH(W)) bus ();

    sipo_receiver #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic a);
        bus.en  = 1'b1;
        bus.sin = b;
        bus.ack = a;
        tick();
        bus.en  = 1'b0;
        bus.ack = 1'b0;
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"},    32'(bus.data),    32'(m_data));
        check({tag, "_valid"},   32'(bus.valid),   32'(m_valid));
        check({tag, "_overrun"}, 32'(bus.overrun), 32'(m_over));
    endtask

    // Pop the scoreboard entry for a completion and compare it with data.
    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            assert (bus.data === e) else begin
                failures++;
                $error("FAIL %s_sb observed=%0h expected=%0h", tag, bus.data, e);
            end
        end
    endtask

    // Full frame: start, MSB-first bits, optional gaps, ack on the last bit.
    task automatic send_frame(input string tag, input logic [W-1:0] word,
                              input bit gapped, input logic ack_last);
        do_start();
        for (int k = 0; k < W; k++) begin
            if (gapped && k > 0) begin
                for (int g = 0; g < (k % 4); g++) begin
                    tick();
                    check({tag, "_gapbusy"}, 32'(bus.busy), 32'd1);
                end
            end
            send_bit(word[W-1-k], (k == W-1) ? ack_last : 1'b0);
        end
        if (!m_valid || ack_last) begin
            m_data  = word;
            m_valid = 1'b1;
        end else begin
            m_over = 1'b1;
        end
        exp_q.push_back(m_data);
        pop_check(tag);
        check_outputs(tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic consume(input string tag);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        m_valid = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.en    = 1'b0;
        bus.sin   = 1'b0;
        bus.ack   = 1'b0;
        model_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_outputs("reset");
        check("reset_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        #4 rst = 1'b0;

        // Basic frame, then consume it.
        send_frame("basic", 6'b101101, 1'b0, 1'b0);
        consume("basic_ack");

        // ack with valid=0 has no effect.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_outputs("idle_ack");

        // Gapped bits.
        send_frame("gapped", 6'b101101, 1'b1, 1'b0);
        consume("gapped_ack");

        // Overrun: second frame dropped while first is unconsumed.
        send_frame("ovr1", 6'b111000, 1'b0, 1'b0);
        send_frame("ovr2", 6'b000111, 1'b0, 1'b0);
        check("ovr2_data_kept", 32'(bus.data), 32'(6'b111000));
        consume("ovr_ack");
        tick();
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Clear overrun with an asynchronous reset pulse between edges.
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_outputs("rst_pulse");
        #2 rst = 1'b0;
        tick();

        // ack coinciding with completion takes the new word.
        send_frame("simul1", 6'b010101, 1'b0, 1'b0);
        send_frame("simul2", 6'b110011, 1'b0, 1'b1);
        consume("simul_ack");

        // Restart mid-frame.
        do_start();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("restart_partial_valid", 32'(bus.valid), 32'd0);
        check("restart_partial_busy", 32'(bus.busy), 32'd1);
        send_frame("restart", 6'b000001, 1'b0, 1'b0);
        consume("restart_ack");

        // Async reset mid-frame discards it; no frame without a new start.
        send_frame("pre_rst", 6'b100110, 1'b0, 1'b0);
        do_start();
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_outputs("midrst");
        check("midrst_busy", 32'(bus.busy), 32'd0);
        #2 rst = 1'b0;
        tick();
        for (int k = 0; k < W; k++) send_bit(k[0], 1'b0);
        check_outputs("nostart");
        check("nostart_busy", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
